// File: rtl/tetris_pkg.sv
// Shared types and default board geometry for the Tetris game logic.
// The piece move checker and its column sub-check use these definitions.
package tetris_pkg;

  localparam int BOARD_WIDTH_DEF  = 10;
  localparam int BOARD_HEIGHT_DEF = 20;
  localparam int GRID_SIZE_DEF    = 4;

  typedef enum logic [1:0] {
    MODE_PLACE = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_LEFT  = 2'd2,
    MODE_RIGHT = 2'd3
  } move_mode_t;

  // Piece bits indexed [px][py], py=0 is the top row of the grid.
  typedef logic [GRID_SIZE_DEF-1:0][GRID_SIZE_DEF-1:0] piece_grid_t;

  typedef struct packed {
    logic                               collide;
    logic                               oob;
    logic                               landed;
    logic [$clog2(GRID_SIZE_DEF)-1:0]   hit_col;
  } check_result_t;

endpackage

// File: rtl/column_overlap_check.sv
// Checks one piece-grid column at board column bx against the fixed board
// column, flagging overlap, wall out-of-bounds and floor out-of-bounds.
module column_overlap_check #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20,
  parameter int GRID_SIZE    = 4,
  parameter int XW           = $clog2(BOARD_WIDTH) + 2,
  parameter int YW           = $clog2(BOARD_HEIGHT) + 2
) (
  input  logic [GRID_SIZE-1:0]    col_bits,
  input  logic signed [XW:0]      bx,
  input  logic signed [YW-1:0]    cy,
  input  logic [BOARD_HEIGHT-1:0] board_col,
  output logic                    collide,
  output logic                    wall_oob,
  output logic                    floor_oob
);

  localparam int HI = $clog2(BOARD_HEIGHT);
  localparam logic signed [XW:0] W_S = (XW+1)'(BOARD_WIDTH);
  localparam logic signed [YW:0] H_S = (YW+1)'(BOARD_HEIGHT);

  logic               col_wall;
  logic signed [YW:0] by;

  assign col_wall = bx[XW] || (bx >= W_S);

  always_comb begin
    collide   = 1'b0;
    wall_oob  = 1'b0;
    floor_oob = 1'b0;
    by        = '0;
    for (int py = 0; py < GRID_SIZE; py++) begin
      by = (YW+1)'(cy) + $signed((YW+1)'(py));
      if (col_bits[py]) begin
        if (col_wall) wall_oob = 1'b1;
        // Rows above the board (by < 0) are legal and never looked up.
        if (!by[YW] && by >= H_S) begin
          floor_oob = 1'b1;
        end else if (!by[YW] && !col_wall && board_col[by[HI-1:0]]) begin
          collide = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/piece_move_checker.sv
// Sequential move/landing legality check: forms the candidate position from the
// request, then scans the piece one grid column per cycle against the fixed board.
module piece_move_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_WIDTH  = BOARD_WIDTH_DEF,
  parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEF,
  parameter int GRID_SIZE    = GRID_SIZE_DEF,
  parameter int XW           = $clog2(BOARD_WIDTH) + 2,
  parameter int YW           = $clog2(BOARD_HEIGHT) + 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  move_mode_t                          req_mode,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]      req_grid,
  input  logic signed [XW-1:0]                req_x,
  input  logic signed [YW-1:0]                req_y,
  input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] fixed_screen,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic                                resp_collide,
  output logic                                resp_oob,
  output logic                                resp_landed,
  output logic [$clog2(GRID_SIZE)-1:0]        resp_hit_col,
  output logic [1:0]                          fsm_state
);

  // Handshake: a request is taken on a cycle with req_valid & req_ready, and a
  // result is released on a cycle with resp_valid & resp_ready; resp_valid and
  // the result fields hold steady until then.

  localparam int CW = $clog2(GRID_SIZE);
  localparam int BW = $clog2(BOARD_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic signed [XW-1:0] ONE_X = XW'(1);
  localparam logic signed [YW-1:0] ONE_Y = YW'(1);
  localparam logic signed [XW:0]   W_S   = (XW+1)'(BOARD_WIDTH);
  localparam logic [CW-1:0]        LAST  = CW'(GRID_SIZE - 1);

  logic [1:0]                       state;
  move_mode_t                       mode_q;
  logic [GRID_SIZE*GRID_SIZE-1:0]   grid_q;
  logic signed [XW-1:0]             cx_q;
  logic signed [YW-1:0]             cy_q;
  logic [CW-1:0]                    col_q;
  logic                             collide_q;
  logic                             oob_q;
  logic                             landed_q;
  logic [CW-1:0]                    hit_col_q;

  logic signed [XW-1:0]             cx_next;
  logic signed [YW-1:0]             cy_next;
  logic signed [XW:0]               bx;
  logic                             bx_on_board;
  logic [BOARD_HEIGHT-1:0]          screen_cols [BOARD_WIDTH];
  logic [BOARD_HEIGHT-1:0]          board_col;
  logic [GRID_SIZE-1:0]             col_bits;
  logic                             col_collide;
  logic                             col_wall;
  logic                             col_floor;
  logic                             col_fail;

  for (genvar gx = 0; gx < BOARD_WIDTH; gx++) begin : g_cols
    assign screen_cols[gx] = fixed_screen[gx*BOARD_HEIGHT +: BOARD_HEIGHT];
  end

  always_comb begin
    cx_next = req_x;
    cy_next = req_y;
    case (req_mode)
      MODE_DOWN:  cy_next = req_y + ONE_Y;
      MODE_LEFT:  cx_next = req_x - ONE_X;
      MODE_RIGHT: cx_next = req_x + ONE_X;
      default:    ;
    endcase
  end

  assign bx          = (XW+1)'(cx_q) + $signed((XW+1)'(col_q));
  assign bx_on_board = !bx[XW] && (bx < W_S);
  assign board_col   = bx_on_board ? screen_cols[bx[BW-1:0]] : '0;
  assign col_bits    = grid_q[col_q*GRID_SIZE +: GRID_SIZE];

  column_overlap_check #(
    .BOARD_WIDTH  (BOARD_WIDTH),
    .BOARD_HEIGHT (BOARD_HEIGHT),
    .GRID_SIZE    (GRID_SIZE),
    .XW           (XW),
    .YW           (YW)
  ) u_col_check (
    .col_bits  (col_bits),
    .bx        (bx),
    .cy        (cy_q),
    .board_col (board_col),
    .collide   (col_collide),
    .wall_oob  (col_wall),
    .floor_oob (col_floor)
  );

  assign col_fail = col_collide | col_wall | col_floor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_PLACE;
      grid_q    <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      col_q     <= '0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
      landed_q  <= 1'b0;
      hit_col_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_SCAN;
            mode_q    <= req_mode;
            grid_q    <= req_grid;
            cx_q      <= cx_next;
            cy_q      <= cy_next;
            col_q     <= '0;
            collide_q <= 1'b0;
            oob_q     <= 1'b0;
            landed_q  <= 1'b0;
            hit_col_q <= '0;
          end
        end
        ST_SCAN: begin
          // Stop at the first failing column; later columns cannot change the verdict.
          if (col_fail) begin
            state     <= ST_DONE;
            collide_q <= col_collide;
            oob_q     <= col_wall | col_floor;
            landed_q  <= (mode_q == MODE_DOWN) && (col_collide || col_floor);
            hit_col_q <= col_q;
          end else if (col_q == LAST) begin
            state <= ST_DONE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign resp_valid   = (state == ST_DONE);
  assign resp_collide = collide_q;
  assign resp_oob     = oob_q;
  assign resp_landed  = landed_q;
  assign resp_hit_col = hit_col_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_piece_move_checker.sv
// Directed bench for piece_move_checker: vector table plus reset-abort and
// held-result sequences, scored against hand-computed expectations.
module tb_piece_move_checker;
  import tetris_pkg::*;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int G  = 4;
  localparam int XW = $clog2(W) + 2;
  localparam int YW = $clog2(H) + 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  move_mode_t           req_mode = MODE_PLACE;
  logic [G*G-1:0]       req_grid = '0;
  logic signed [XW-1:0] req_x = '0;
  logic signed [YW-1:0] req_y = '0;
  logic [W*H-1:0]       fixed_screen = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic                 resp_collide;
  logic                 resp_oob;
  logic                 resp_landed;
  logic [$clog2(G)-1:0] resp_hit_col;
  logic [1:0]           fsm_state;

  piece_move_checker dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_grid     (req_grid),
    .req_x        (req_x),
    .req_y        (req_y),
    .fixed_screen (fixed_screen),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_collide (resp_collide),
    .resp_oob     (resp_oob),
    .resp_landed  (resp_landed),
    .resp_hit_col (resp_hit_col),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    move_mode_t  mode;
    logic [15:0] grid;
    int          x;
    int          y;
    bit          fen;
    int          fx;
    int          fy;
    bit          e_col;
    bit          e_oob;
    bit          e_land;
    int          e_hit;
    int          e_lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic load_req(input vec_t v);
    fixed_screen = '0;
    if (v.fen) fixed_screen[v.fx*H + v.fy] = 1'b1;
    req_mode = v.mode;
    req_grid = v.grid;
    req_x    = XW'(v.x);
    req_y    = YW'(v.y);
  endtask

  // Presents one request and counts clock edges, including the accept edge,
  // until resp_valid rises.
  task automatic run_req(input vec_t v, output int lat);
    load_req(v);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    // mode, grid, x, y, fixed?, fx, fy, collide, oob, landed, hit_col, latency
    vecs[0]  = '{MODE_DOWN,  16'h0660,  3,  0, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 0, 5};
    vecs[1]  = '{MODE_DOWN,  16'h000F,  4, 16, 1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 0, 2};
    vecs[2]  = '{MODE_DOWN,  16'h0131,  3,  9, 1'b1, 5, 10, 1'b1, 1'b0, 1'b1, 2, 4};
    vecs[3]  = '{MODE_LEFT,  16'h0047,  0,  5, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 0, 2};
    vecs[4]  = '{MODE_RIGHT, 16'h0047,  6,  5, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 0, 5};
    vecs[5]  = '{MODE_PLACE, 16'h0330,  3, -2, 1'b1, 4,  0, 1'b0, 1'b0, 1'b0, 0, 5};
    vecs[6]  = '{MODE_PLACE, 16'h0000, -3, 25, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 0, 5};
    vecs[7]  = '{MODE_RIGHT, 16'h1000,  6,  0, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 3, 5};
    vecs[8]  = '{MODE_PLACE, 16'h0660,  3,  0, 1'b1, 4,  1, 1'b1, 1'b0, 1'b0, 1, 3};
    vecs[9]  = '{MODE_LEFT,  16'h0660,  3,  5, 1'b1, 3,  7, 1'b1, 1'b0, 1'b0, 1, 3};
    vecs[10] = '{MODE_DOWN,  16'h0660,  3, 17, 1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 1, 3};
    vecs[11] = '{MODE_DOWN,  16'h000F,  0,  0, 1'b1, 0,  4, 1'b1, 1'b0, 1'b1, 0, 2};
    vecs[12] = '{MODE_PLACE, 16'h00F0, -1,  0, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 0, 5};
    vecs[13] = '{MODE_RIGHT, 16'h0F00,  7,  0, 1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 2, 4};

    // Clock/reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset req_ready", 32'(req_ready), 1);
    check("reset resp_valid", 32'(resp_valid), 0);
    check("reset flags", {29'd0, resp_collide, resp_oob, resp_landed}, 0);
    check("reset hit_col", 32'(resp_hit_col), 0);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].e_lat));
      check($sformatf("v%0d collide", i), 32'(resp_collide), 32'(vecs[i].e_col));
      check($sformatf("v%0d oob", i), 32'(resp_oob), 32'(vecs[i].e_oob));
      check($sformatf("v%0d landed", i), 32'(resp_landed), 32'(vecs[i].e_land));
      check($sformatf("v%0d hit_col", i), 32'(resp_hit_col), 32'(vecs[i].e_hit));
      check($sformatf("v%0d req_ready in done", i), 32'(req_ready), 0);
      release_resp();
      check($sformatf("v%0d resp_valid released", i), 32'(resp_valid), 0);
      check($sformatf("v%0d req_ready released", i), 32'(req_ready), 1);
    end

    // Reset during the second scan cycle aborts the request.
    load_req(vecs[0]);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("abort in scan", 32'(req_ready), 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort req_ready", 32'(req_ready), 1);
    check("abort resp_valid", 32'(resp_valid), 0);
    for (int i = 0; i < 6; i++) tick();
    check("abort stays idle", 32'(resp_valid), 0);

    // Result held while the consumer stalls; a waiting request is not taken.
    load_req(vecs[1]);
    req_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d resp_valid", i), 32'(resp_valid), 1);
      check($sformatf("hold%0d flags", i), {29'd0, resp_collide, resp_oob, resp_landed}, 3);
      check($sformatf("hold%0d req_ready", i), 32'(req_ready), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("hold released resp_valid", 32'(resp_valid), 0);
    check("hold released req_ready", 32'(req_ready), 1);
    req_valid = 1'b0;
    tick();
    check("hold idle req_ready", 32'(req_ready), 1);

    // Flags from the previous request must not leak into the next one.
    run_req(vecs[4], lat);
    check("clear latency", 32'(lat), 5);
    check("clear flags", {29'd0, resp_collide, resp_oob, resp_landed}, 0);
    release_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
